// File: rtl/spawn_pkg.sv
// Shared state enum, field widths and default screen constants for the spawn scheduler.
// Optional feature macro honoured by spawn_scheduler: SPAWN_SPREAD_EN.
package spawn_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SAMPLE = 2'd1,
      MOVE   = 2'd2,
      SPAWN  = 2'd3
   } state_t;

   localparam int X_W  = 10;
   localparam int Y_W  = 9;
   localparam int CD_W = 8;

   localparam int DEF_SLOTS        = 8;
   localparam int DEF_SCREEN_W     = 640;
   localparam int DEF_SCREEN_H     = 480;
   localparam int DEF_OBJ_W        = 16;
   localparam int DEF_SPAWN_PERIOD = 30;
   localparam int DEF_FALL_SPEED   = 2;

endpackage

// File: rtl/spawn_scheduler_x_map.sv
// Folds a 10-bit random value into 0..X_RANGE-1 with one conditional subtract;
// this is exact because 2*X_RANGE covers the whole 10-bit input range.
module x_map
   import spawn_pkg::*;
#(
   parameter int X_RANGE = DEF_SCREEN_W - DEF_OBJ_W + 1
)(
   input  logic [X_W-1:0] rand_v,
   output logic [X_W-1:0] x
);

   localparam logic [X_W-1:0] RANGE_V = X_W'(X_RANGE);

   assign x = (rand_v >= RANGE_V) ? (rand_v - RANGE_V) : rand_v;

endmodule

// File: rtl/spawn_scheduler.sv
// Per-frame falling-object slot table: sample random, move/retire, periodic spawn.
// Optional SPAWN_SPREAD_EN defers spawns landing within OBJ_W of the previous spawn x.
//
//   state  | meaning
//   IDLE   | waiting for frame & enable
//   SAMPLE | latch rand_i into rand_q
//   MOVE   | advance live objects, retire off-screen ones, tick countdown
//   SPAWN  | place new object in lowest free slot when countdown is zero
module spawn_scheduler
   import spawn_pkg::*;
#(
   parameter int SLOTS        = DEF_SLOTS,
   parameter int SCREEN_W     = DEF_SCREEN_W,
   parameter int SCREEN_H     = DEF_SCREEN_H,
   parameter int OBJ_W        = DEF_OBJ_W,
   parameter int SPAWN_PERIOD = DEF_SPAWN_PERIOD,
   parameter int FALL_SPEED   = DEF_FALL_SPEED
)(
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 frame,
   input  logic [X_W-1:0]       rand_i,
   input  logic                 enable,
   input  logic [SLOTS-1:0]     clear_i,
   output logic [SLOTS-1:0]     obj_valid,
   output logic [SLOTS*X_W-1:0] obj_x,
   output logic [SLOTS*Y_W-1:0] obj_y,
   output logic                 spawn_drop,
   output logic                 miss,
   output logic                 done
);

   localparam int              X_RANGE = SCREEN_W - OBJ_W + 1;
   localparam logic [Y_W:0]    Y_LIMIT = (Y_W+1)'(SCREEN_H);
   localparam logic [Y_W:0]    Y_STEP  = (Y_W+1)'(FALL_SPEED);
   localparam logic [CD_W-1:0] CD_LOAD = CD_W'(SPAWN_PERIOD - 1);

   state_t           state, state_nxt;
   logic             do_sample, do_move, do_spawn;
   logic [X_W-1:0]   rand_q, spawn_x;
   logic [CD_W-1:0]  countdown;
   logic [SLOTS-1:0] valid_q, off_screen, free, spawn_sel;
   logic [X_W-1:0]   x_q [SLOTS];
   logic [Y_W-1:0]   y_q [SLOTS];
   logic [Y_W:0]     y_next [SLOTS];
   logic             spread_ok, spawn_due;

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (frame && enable) state_nxt = SAMPLE;
         SAMPLE:  state_nxt = MOVE;
         MOVE:    state_nxt = SPAWN;
         SPAWN:   state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      do_sample = 1'b0;
      do_move   = 1'b0;
      do_spawn  = 1'b0;
      case (state)
         SAMPLE:  do_sample = 1'b1;
         MOVE:    do_move   = 1'b1;
         SPAWN:   do_spawn  = 1'b1;
         default: ;
      endcase
   end

   x_map #(.X_RANGE(X_RANGE)) u_x_map (
      .rand_v (rand_q),
      .x      (spawn_x)
   );

   always_comb begin
      for (int k = 0; k < SLOTS; k++) begin
         y_next[k]     = {1'b0, y_q[k]} + Y_STEP;
         off_screen[k] = (y_next[k] >= Y_LIMIT);
      end
   end

   // clear_i lands in the same cycle, so valid_q already holds every earlier clear;
   // a clear colliding with the spawn write loses to the spawn.
   assign free      = ~valid_q;
   assign spawn_due = do_spawn && (countdown == '0) && spread_ok;
   assign spawn_sel = spawn_due ? (free & (~free + SLOTS'(1))) : '0;

`ifdef SPAWN_SPREAD_EN
   localparam logic [X_W-1:0] SPREAD_MIN = X_W'(OBJ_W);
   logic [X_W-1:0] last_x, x_dist;

   always_comb begin
      x_dist    = (spawn_x >= last_x) ? (spawn_x - last_x) : (last_x - spawn_x);
      spread_ok = (x_dist >= SPREAD_MIN);
   end

   always_ff @(posedge clk) begin
      if (rst)                             last_x <= '0;
      else if (spawn_due && (free != '0))  last_x <= spawn_x;
   end
`else
   assign spread_ok = 1'b1;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q    <= '0;
         rand_q     <= '0;
         countdown  <= '0;
         miss       <= 1'b0;
         spawn_drop <= 1'b0;
         done       <= 1'b0;
         for (int k = 0; k < SLOTS; k++) begin
            x_q[k] <= '0;
            y_q[k] <= '0;
         end
      end else begin
         if (do_sample) rand_q <= rand_i;
         for (int k = 0; k < SLOTS; k++) begin
            if (spawn_sel[k]) begin
               valid_q[k] <= 1'b1;
               x_q[k]     <= spawn_x;
               y_q[k]     <= '0;
            end else if (clear_i[k]) begin
               valid_q[k] <= 1'b0;
            end else if (do_move && valid_q[k]) begin
               if (off_screen[k]) valid_q[k] <= 1'b0;
               else               y_q[k]     <= y_next[k][Y_W-1:0];
            end
         end
         if (do_move && (countdown != '0))        countdown <= countdown - CD_W'(1);
         else if (spawn_due && (free != '0))      countdown <= CD_LOAD;
         miss       <= do_move && |(valid_q & off_screen);
         spawn_drop <= spawn_due && (free == '0);
         done       <= do_spawn;
      end
   end

   assign obj_valid = valid_q;

   for (genvar k = 0; k < SLOTS; k++) begin : g_pack
      assign obj_x[k*X_W +: X_W] = x_q[k];
      assign obj_y[k*Y_W +: Y_W] = y_q[k];
   end

endmodule

// File: tb/tb_spawn_scheduler.sv
// Scoreboard bench: a default instance and a period-1 instance share all stimulus;
// a frame-level model pushes expected tables that are popped at T+3 / T+4.
module tb_spawn_scheduler;

   localparam int NS   = 8;
   localparam int PER0 = 30;
   localparam int PER1 = 1;

   typedef struct packed {
      logic        miss;
      logic        drop;
      logic [7:0]  valid;
      logic [79:0] x;
      logic [71:0] y;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst, frame, enable;
   logic [9:0]  rand_i;
   logic [7:0]  clear_i;
   logic [7:0]  valid0, valid1;
   logic [79:0] x0, x1;
   logic [71:0] y0, y1;
   logic        drop0, drop1, miss0, miss1, done0, done1;

   int vectors = 0;
   int miscompares = 0;

   exp_t q0[$];
   exp_t q1[$];

   logic [7:0] m_v [2];
   logic [9:0] m_x [2][NS];
   logic [8:0] m_y [2][NS];
   int         m_cd [2];
   logic [9:0] m_last [2];

   always #5 clk = ~clk;

   spawn_scheduler u_dut0 (
      .clk(clk), .rst(rst), .frame(frame), .rand_i(rand_i), .enable(enable),
      .clear_i(clear_i), .obj_valid(valid0), .obj_x(x0), .obj_y(y0),
      .spawn_drop(drop0), .miss(miss0), .done(done0)
   );

   spawn_scheduler #(.SPAWN_PERIOD(PER1)) u_dut1 (
      .clk(clk), .rst(rst), .frame(frame), .rand_i(rand_i), .enable(enable),
      .clear_i(clear_i), .obj_valid(valid1), .obj_x(x1), .obj_y(y1),
      .spawn_drop(drop1), .miss(miss1), .done(done1)
   );

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   function automatic logic [9:0] map_x(input logic [9:0] r);
      if (r >= 10'd625) return r - 10'd625;
      return r;
   endfunction

   function automatic logic [9:0] edge_val(input int n);
      case (n)
         0:       return 10'd624;
         1:       return 10'd625;
         2:       return 10'd626;
         3:       return 10'd1023;
         4:       return 10'd0;
         default: return 10'd1;
      endcase
   endfunction

   function automatic exp_t snap(input int i, input logic mi, input logic dr);
      exp_t e;
      e.miss  = mi;
      e.drop  = dr;
      e.valid = m_v[i];
      e.x     = '0;
      e.y     = '0;
      for (int k = 0; k < NS; k++) begin
         e.x[10*k +: 10] = m_x[i][k];
         e.y[9*k +: 9]   = m_y[i][k];
      end
      return e;
   endfunction

   task automatic model_reset;
      q0.delete();
      q1.delete();
      for (int i = 0; i < 2; i++) begin
         m_v[i]    = '0;
         m_cd[i]   = 0;
         m_last[i] = '0;
         for (int k = 0; k < NS; k++) begin
            m_x[i][k] = '0;
            m_y[i][k] = '0;
         end
      end
   endtask

   task automatic model_frame(input logic [9:0] r, input logic [7:0] clr);
      for (int i = 0; i < 2; i++) begin
         logic       mi, dr, ok;
         int         sel, yn;
         logic [9:0] xs;
         mi  = 1'b0;
         dr  = 1'b0;
         sel = -1;
         for (int k = 0; k < NS; k++) begin
            if (m_v[i][k]) begin
               yn = int'(m_y[i][k]) + 2;
               if (yn >= 480) begin
                  m_v[i][k] = 1'b0;
                  mi = 1'b1;
               end else begin
                  m_y[i][k] = 9'(yn);
               end
            end
         end
         if (m_cd[i] != 0) m_cd[i] = m_cd[i] - 1;
         if (m_cd[i] == 0) begin
            xs = map_x(r);
            ok = 1'b1;
`ifdef SPAWN_SPREAD_EN
            begin
               logic [9:0] d;
               d  = (xs >= m_last[i]) ? xs - m_last[i] : m_last[i] - xs;
               ok = (d >= 10'd16);
            end
`endif
            if (ok) begin
               for (int k = NS-1; k >= 0; k--)
                  if (!m_v[i][k]) sel = k;
               if (sel >= 0) begin
                  m_v[i][sel] = 1'b1;
                  m_x[i][sel] = xs;
                  m_y[i][sel] = '0;
                  m_cd[i]     = ((i == 0) ? PER0 : PER1) - 1;
                  m_last[i]   = xs;
               end else begin
                  dr = 1'b1;
               end
            end
         end
         for (int k = 0; k < NS; k++)
            if (clr[k] && k != sel) m_v[i][k] = 1'b0;
         if (i == 0) q0.push_back(snap(0, mi, dr));
         else        q1.push_back(snap(1, mi, dr));
      end
   endtask

   // Drives one frame from IDLE; returns in T+4 with the table checked against the scoreboard.
   task automatic run_frame(input logic [9:0] r, input logic [7:0] clr, input logic move_frame,
                            input logic drop_en, output logic seen_miss0);
      exp_t        e;
      logic        gm, gd, gdn;
      logic [7:0]  gv;
      logic [79:0] gx;
      logic [71:0] gy;
      model_frame(r, clr);
      frame  = 1'b1;
      rand_i = r;
      enable = 1'b1;
      step();
      frame = 1'b0;
      if (drop_en) enable = 1'b0;
      step();
      frame = move_frame;
      step();
      frame      = 1'b0;
      clear_i    = clr;
      seen_miss0 = miss0;
      for (int i = 0; i < 2; i++) begin
         e   = (i == 0) ? q0[0] : q1[0];
         gm  = (i == 0) ? miss0 : miss1;
         gdn = (i == 0) ? done0 : done1;
         vectors++;
         if (gm !== e.miss) begin
            miscompares++;
            $display("FAIL dut%0d miss_t3: got %b want %b", i, gm, e.miss);
         end
         vectors++;
         if (gdn !== 1'b0) begin
            miscompares++;
            $display("FAIL dut%0d done_t3: got %b want 0", i, gdn);
         end
      end
      step();
      clear_i = '0;
      enable  = 1'b1;
      for (int i = 0; i < 2; i++) begin
         if (i == 0) e = q0.pop_front();
         else        e = q1.pop_front();
         gm  = (i == 0) ? miss0  : miss1;
         gd  = (i == 0) ? drop0  : drop1;
         gdn = (i == 0) ? done0  : done1;
         gv  = (i == 0) ? valid0 : valid1;
         gx  = (i == 0) ? x0     : x1;
         gy  = (i == 0) ? y0     : y1;
         vectors++;
         if (gdn !== 1'b1) begin
            miscompares++;
            $display("FAIL dut%0d done_t4: got %b want 1", i, gdn);
         end
         vectors++;
         if (gd !== e.drop) begin
            miscompares++;
            $display("FAIL dut%0d spawn_drop_t4: got %b want %b", i, gd, e.drop);
         end
         vectors++;
         if (gm !== 1'b0) begin
            miscompares++;
            $display("FAIL dut%0d miss_t4: got %b want 0", i, gm);
         end
         vectors++;
         if (gv !== e.valid) begin
            miscompares++;
            $display("FAIL dut%0d obj_valid: got %h want %h", i, gv, e.valid);
         end
         vectors++;
         if (gx !== e.x) begin
            miscompares++;
            $display("FAIL dut%0d obj_x: got %h want %h", i, gx, e.x);
         end
         vectors++;
         if (gy !== e.y) begin
            miscompares++;
            $display("FAIL dut%0d obj_y: got %h want %h", i, gy, e.y);
         end
      end
   endtask

   task automatic test_reset;
      rst     = 1'b1;
      frame   = 1'b0;
      enable  = 1'b0;
      rand_i  = '0;
      clear_i = '0;
      step();
      step();
      rst = 1'b0;
      model_reset();
      vectors++;
      if ({valid0, valid1} !== 16'h0) begin
         miscompares++;
         $display("FAIL reset_valid: got %h want 0", {valid0, valid1});
      end
      vectors++;
      if ({x0, x1, y0, y1} !== '0) begin
         miscompares++;
         $display("FAIL reset_xy: got x0=%h y0=%h want 0", x0, y0);
      end
      vectors++;
      if ({drop0, miss0, done0, drop1, miss1, done1} !== 6'b0) begin
         miscompares++;
         $display("FAIL reset_pulses: got %b want 000000", {drop0, miss0, done0, drop1, miss1, done1});
      end
   endtask

   task automatic test_first_spawn;
      logic sm;
      run_frame(10'd700, 8'h00, 1'b0, 1'b0, sm);
      vectors++;
      if (valid0 !== 8'h01 || x0[9:0] !== 10'd75 || y0[8:0] !== 9'd0) begin
         miscompares++;
         $display("FAIL first_spawn: got v=%h x=%0d y=%0d want v=01 x=75 y=0", valid0, x0[9:0], y0[8:0]);
      end
   endtask

   task automatic test_period;
      logic sm;
      repeat (30) run_frame(10'd100, 8'h00, 1'b0, 1'b0, sm);
      vectors++;
      if (y0[8:0] !== 9'd60) begin
         miscompares++;
         $display("FAIL period_slot0_y: got %0d want 60", y0[8:0]);
      end
      vectors++;
      if (valid0 !== 8'h03 || x0[19:10] !== 10'd100 || y0[17:9] !== 9'd2) begin
         miscompares++;
         $display("FAIL period_slot1: got v=%h x=%0d y=%0d want v=03 x=100 y=2", valid0, x0[19:10], y0[17:9]);
      end
   endtask

   task automatic test_drop_and_clear;
      logic sm;
      test_reset();
      for (int k = 0; k < 9; k++) run_frame(10'(60*k + 40), 8'h00, 1'b0, 1'b0, sm);
      vectors++;
      if (valid1 !== 8'hff || drop1 !== 1'b1) begin
         miscompares++;
         $display("FAIL drop_full: got v=%h drop=%b want v=ff drop=1", valid1, drop1);
      end
      clear_i = 8'h08;
      step();
      clear_i = 8'h00;
      m_v[0][3] = 1'b0;
      m_v[1][3] = 1'b0;
      run_frame(10'd900, 8'h00, 1'b0, 1'b0, sm);
      vectors++;
      if (valid1 !== 8'hff || x1[39:30] !== 10'd275 || drop1 !== 1'b0) begin
         miscompares++;
         $display("FAIL refill_slot3: got v=%h x=%0d drop=%b want v=ff x=275 drop=0", valid1, x1[39:30], drop1);
      end
   endtask

   task automatic test_miss;
      logic       sm;
      logic [9:0] r;
      test_reset();
      run_frame(10'd500, 8'h00, 1'b0, 1'b0, sm);
      for (int f = 2; f <= 240; f++) begin
         r = (f < 8) ? edge_val(f - 2) : 10'($urandom_range(0, 1023));
         run_frame(r, 8'h00, 1'b0, 1'b0, sm);
      end
      vectors++;
      if (valid0[0] !== 1'b1 || y0[8:0] !== 9'd478) begin
         miscompares++;
         $display("FAIL pre_miss_slot0: got v=%b y=%0d want v=1 y=478", valid0[0], y0[8:0]);
      end
      run_frame(10'($urandom_range(0, 1023)), 8'h00, 1'b0, 1'b0, sm);
      vectors++;
      if (sm !== 1'b1) begin
         miscompares++;
         $display("FAIL miss_t3_offscreen: got %b want 1", sm);
      end
   endtask

   task automatic test_spawn_wins;
      logic sm, seen;
      test_reset();
      run_frame(10'd300, 8'h00, 1'b0, 1'b0, sm);
      clear_i = 8'h01;
      step();
      clear_i = 8'h00;
      m_v[0][0] = 1'b0;
      m_v[1][0] = 1'b0;
      run_frame(10'd500, 8'h01, 1'b1, 1'b0, sm);
      vectors++;
      if (valid1[0] !== 1'b1 || x1[9:0] !== 10'd500 || valid0[0] !== 1'b0) begin
         miscompares++;
         $display("FAIL spawn_wins: got v1=%b x1=%0d v0=%b want v1=1 x1=500 v0=0", valid1[0], x1[9:0], valid0[0]);
      end
      seen = 1'b0;
      repeat (6) begin
         step();
         seen = seen | done0 | done1;
      end
      vectors++;
      if (seen !== 1'b0) begin
         miscompares++;
         $display("FAIL frame_in_move_ignored: got done=%b want 0", seen);
      end
   endtask

   task automatic test_enable;
      logic sm, seen;
      enable = 1'b0;
      frame  = 1'b1;
      rand_i = 10'd7;
      step();
      frame = 1'b0;
      seen  = 1'b0;
      repeat (6) begin
         step();
         seen = seen | done0 | done1;
      end
      vectors++;
      if (seen !== 1'b0) begin
         miscompares++;
         $display("FAIL disabled_frame: got done=%b want 0", seen);
      end
      vectors++;
      if (valid0 !== m_v[0] || valid1 !== m_v[1]) begin
         miscompares++;
         $display("FAIL frozen_table: got %h/%h want %h/%h", valid0, valid1, m_v[0], m_v[1]);
      end
      run_frame(10'd800, 8'h00, 1'b0, 1'b1, sm);
   endtask

   task automatic test_reset_mid;
      logic sm, seen;
      frame  = 1'b1;
      enable = 1'b1;
      rand_i = 10'd600;
      step();
      frame = 1'b0;
      step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      model_reset();
      seen = 1'b0;
      repeat (4) begin
         step();
         seen = seen | done0 | done1 | miss0 | miss1;
      end
      vectors++;
      if (seen !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_mid_pulses: got %b want 0", seen);
      end
      vectors++;
      if ({valid0, valid1} !== 16'h0 || {x0, x1} !== '0) begin
         miscompares++;
         $display("FAIL reset_mid_table: got v=%h%h want 0", valid0, valid1);
      end
      run_frame(10'd700, 8'h00, 1'b0, 1'b0, sm);
      vectors++;
      if (valid0 !== 8'h01 || x0[9:0] !== 10'd75) begin
         miscompares++;
         $display("FAIL reset_mid_respawn: got v=%h x=%0d want v=01 x=75", valid0, x0[9:0]);
      end
   endtask

   task automatic test_spread;
      logic       sm;
      logic [7:0] exp_v;
      int         s;
      test_reset();
      run_frame(10'd100, 8'h00, 1'b0, 1'b0, sm);
      run_frame(10'd110, 8'h00, 1'b0, 1'b0, sm);
`ifdef SPAWN_SPREAD_EN
      exp_v = 8'h01;
`else
      exp_v = 8'h03;
`endif
      vectors++;
      if (valid1 !== exp_v) begin
         miscompares++;
         $display("FAIL spread_near: got %h want %h", valid1, exp_v);
      end
      run_frame(10'd200, 8'h00, 1'b0, 1'b0, sm);
`ifdef SPAWN_SPREAD_EN
      exp_v = 8'h03;
      s = 1;
`else
      exp_v = 8'h07;
      s = 2;
`endif
      vectors++;
      if (valid1 !== exp_v || x1[10*s +: 10] !== 10'd200) begin
         miscompares++;
         $display("FAIL spread_far: got v=%h x=%0d want v=%h x=200", valid1, x1[10*s +: 10], exp_v);
      end
   endtask

   initial begin
      rst     = 1'b1;
      frame   = 1'b0;
      enable  = 1'b0;
      rand_i  = '0;
      clear_i = '0;
      test_reset();
      test_first_spawn();
      test_period();
      test_drop_and_clear();
      test_miss();
      test_spawn_wins();
      test_enable();
      test_reset_mid();
      test_spread();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
